// File: rtl/i2s_transmitter.sv
// I2S controller transmitter: generates SCK/WS/SD from the fabric clock and
// shifts stereo pairs out MSB-first in 32-bit slots with the I2S one-bit delay.
module i2s_transmitter #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SCK_HALF     = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_left_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    i2s_sck_out,
  output logic                    i2s_ws_out,
  output logic                    i2s_sd_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  localparam int unsigned DIV_W   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int unsigned PAD_W   = 32 - SAMPLE_WIDTH;
  localparam int unsigned FRAME_W = 64;
  localparam int unsigned IDX_W   = 6;

  // Left-justify a sample in a 32-bit slot, zero-filling the LSBs.
  function automatic logic [31:0] to_slot(input logic [SAMPLE_WIDTH-1:0] s);
    return 32'(s) << PAD_W;
  endfunction

  logic [DIV_W-1:0]        div_cnt;
  logic                    started;
  logic [IDX_W-1:0]        bit_idx;
  logic [FRAME_W-1:0]      frame_sr;
  logic                    holding_full;
  logic [SAMPLE_WIDTH-1:0] hold_left;
  logic [SAMPLE_WIDTH-1:0] hold_right;

  logic                    div_wrap_c;
  logic                    fall_c;
  logic                    load_c;
  logic                    accept_c;
  logic                    ws_next_c;
  logic [IDX_W-1:0]        bit_next_c;
  logic [FRAME_W-1:0]      frame_load_c;
  logic [FRAME_W-1:0]      frame_src_c;

  // Event decode: divider wrap, fall events, frame position and load source.
  always_comb begin
    div_wrap_c   = (div_cnt == DIV_W'(SCK_HALF - 1));
    fall_c       = div_wrap_c & i2s_sck_out;
    bit_next_c   = started ? (bit_idx + IDX_W'(1)) : '0;
    load_c       = fall_c & (bit_next_c == '0);
    accept_c     = sample_valid_in & sample_ready_out;
    ws_next_c    = (bit_next_c >= IDX_W'(31)) && (bit_next_c <= IDX_W'(62));
    frame_load_c = holding_full ? {to_slot(hold_left), to_slot(hold_right)} : '0;
    frame_src_c  = load_c ? frame_load_c : frame_sr;
  end

  // SCK divider: toggle SCK every SCK_HALF cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt     <= '0;
      i2s_sck_out <= 1'b0;
    end else if (div_wrap_c) begin
      div_cnt     <= '0;
      i2s_sck_out <= ~i2s_sck_out;
    end else begin
      div_cnt     <= div_cnt + DIV_W'(1);
    end
  end

  // Frame position, shift register and serial outputs, all updated on fall events.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      started         <= 1'b0;
      bit_idx         <= '0;
      frame_sr        <= '0;
      i2s_sd_out      <= 1'b0;
      i2s_ws_out      <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      if (fall_c) begin
        started    <= 1'b1;
        bit_idx    <= bit_next_c;
        i2s_sd_out <= frame_src_c[FRAME_W-1];
        frame_sr   <= {frame_src_c[FRAME_W-2:0], 1'b0};
        i2s_ws_out <= ws_next_c;
        if (load_c) begin
          frame_start_out <= 1'b1;
          underrun_out    <= ~holding_full;
        end
      end
    end
  end

  // One-pair holding register; a load frees it, an accept fills it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      holding_full     <= 1'b0;
      sample_ready_out <= 1'b1;
      hold_left        <= '0;
      hold_right       <= '0;
    end else if (accept_c) begin
      holding_full     <= 1'b1;
      sample_ready_out <= 1'b0;
      hold_left        <= sample_left_in;
      hold_right       <= sample_right_in;
    end else if (load_c) begin
      holding_full     <= 1'b0;
      sample_ready_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: stimulus queues expected frames,
// a monitor decodes SD on SCK rises and compares whole frames.
module tb_i2s_transmitter;

  localparam int SW        = 24;
  localparam int SH        = 16;
  localparam int FRAME_CYC = 128 * SH;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [SW-1:0] sample_left_in = '0;
  logic [SW-1:0] sample_right_in = '0;
  logic          sample_valid_in = 1'b0;
  logic          sample_ready_out;
  logic          i2s_sck_out;
  logic          i2s_ws_out;
  logic          i2s_sd_out;
  logic          frame_start_out;
  logic          underrun_out;

  i2s_transmitter #(.SAMPLE_WIDTH(SW), .SCK_HALF(SH)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_left_in   (sample_left_in),
    .sample_right_in  (sample_right_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .i2s_sck_out      (i2s_sck_out),
    .i2s_ws_out       (i2s_ws_out),
    .i2s_sd_out       (i2s_sd_out),
    .frame_start_out  (frame_start_out),
    .underrun_out     (underrun_out)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0;
  int          fails  = 0;
  logic [63:0] exp_q[$];

  // Monitor state
  int          cyc = 0;
  int          mon_pos = 0;
  int          frames_seen = 0;
  int          underruns = 0;
  int          ready_low = 0;
  bit          mon_active = 1'b0;
  bit          ws_bad = 1'b0;
  logic [63:0] cur_exp = '0;
  logic [63:0] got = '0;
  logic        prev_sck = 1'b0;
  logic        prev_ws = 1'b0;
  int          last_rise = 0;
  int          last_wsr = 0;
  bit          have_rise = 1'b0;
  bit          have_wsr = 1'b0;
  int          sck_errs = 0;
  int          ws_errs = 0;
  int          ws_rises = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: frame decode on SCK rises plus SCK/WS period tracking.
  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      mon_active = 1'b0;
      have_rise  = 1'b0;
      have_wsr   = 1'b0;
      prev_sck   = 1'b0;
      prev_ws    = 1'b0;
    end else begin
      if (!sample_ready_out) ready_low++;
      if (frame_start_out) begin
        frames_seen++;
        mon_active = 1'b1;
        mon_pos    = 0;
        ws_bad     = 1'b0;
        got        = '0;
        if (underrun_out) begin
          underruns++;
          cur_exp = '0;
        end else begin
          check("queue_has_entry", 64'(exp_q.size() > 0), 64'(1));
          cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        end
      end
      if (i2s_sck_out && !prev_sck) begin
        if (have_rise && (cyc - last_rise != 2 * SH)) sck_errs++;
        last_rise = cyc;
        have_rise = 1'b1;
        if (mon_active && mon_pos < 64) begin
          got[63 - mon_pos] = i2s_sd_out;
          if (i2s_ws_out != ((mon_pos >= 31) && (mon_pos <= 62))) ws_bad = 1'b1;
          mon_pos++;
          if (mon_pos == 64) begin
            check("frame_data", got, cur_exp);
            check("ws_align", 64'(ws_bad), 64'(0));
            mon_active = 1'b0;
          end
        end
      end
      if (!i2s_sck_out && prev_sck && have_rise && (cyc - last_rise != SH)) sck_errs++;
      if (i2s_ws_out && !prev_ws) begin
        if (have_wsr && (cyc - last_wsr != FRAME_CYC)) ws_errs++;
        last_wsr = cyc;
        have_wsr = 1'b1;
        ws_rises++;
      end
      if (!i2s_ws_out && prev_ws && have_wsr && (cyc - last_wsr != 64 * SH)) ws_errs++;
      prev_sck = i2s_sck_out;
      prev_ws  = i2s_ws_out;
    end
  end

  task automatic check_reset_vals(input string name);
    check(name, 64'({i2s_sck_out, i2s_ws_out, i2s_sd_out, sample_ready_out,
                     frame_start_out, underrun_out}), 64'(6'b000100));
  endtask

  // Called at #1 after the release edge: first rise at 16, first load at 32.
  task automatic measure_restart(input string name);
    int n;
    n = 0;
    while (!i2s_sck_out && n < 200) begin @(posedge clk_in); #1; n++; end
    check({name, "_first_rise"}, 64'(n), 64'(SH));
    while (!frame_start_out && n < 200) begin @(posedge clk_in); #1; n++; end
    check({name, "_first_frame"}, 64'(n), 64'(2 * SH));
    check({name, "_first_underrun"}, 64'(underrun_out), 64'(1));
  endtask

  task automatic wait_frames(input int k);
    int target;
    int n;
    target = frames_seen + k;
    n = 0;
    while (frames_seen < target && n < k * FRAME_CYC + 200) begin
      @(posedge clk_in); #1; n++;
    end
    check("frame_wait", 64'(frames_seen >= target), 64'(1));
  endtask

  // Offer a pair, wait for acceptance, queue its expected frame.
  task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r,
                           input logic [63:0] e, input bit keep);
    int n;
    n = 0;
    sample_left_in  = l;
    sample_right_in = r;
    sample_valid_in = 1'b1;
    while (!sample_ready_out && n < 3 * FRAME_CYC) begin @(posedge clk_in); #1; n++; end
    check("ready_before_accept", 64'(sample_ready_out), 64'(1));
    if (sample_ready_out) begin
      @(posedge clk_in); #1;
      exp_q.push_back(e);
      check("ready_low_after_accept", 64'(sample_ready_out), 64'(0));
    end
    if (!keep) sample_valid_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ur_base;
    int rl_base;
    int n;
    logic [SW-1:0] ln;
    logic [SW-1:0] rn;

    // Reset held for 3 cycles, then restart timing
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_vals("reset_outputs");
    rst_in = 1'b0;
    measure_restart("por");

    // Underrun: two idle frames
    ur_base = underruns;
    rl_base = ready_low;
    wait_frames(2);
    check("underrun_count", 64'(underruns - ur_base), 64'(2));
    check("ready_stayed_high", 64'(ready_low - rl_base), 64'(0));

    // Single frame with hand-computed slots
    send_pair(24'h800001, 24'h7FFFFF, {32'h80000100, 32'h7FFFFF00}, 1'b0);
    wait_frames(2);

    // Backpressure: valid held with (n, ~n)
    ur_base = underruns;
    for (int i = 0; i < 11; i++) begin
      ln = SW'(i);
      rn = ~ln;
      send_pair(ln, rn, {ln, 8'h00, rn, 8'h00}, i < 10);
    end
    wait_frames(1);
    check("no_underrun_backpressure", 64'(underruns - ur_base), 64'(0));
    wait_frames(1);

    // Mid-frame reset with a pair pending
    send_pair(24'h123456, 24'hABCDEF, {32'h12345600, 32'hABCDEF00}, 1'b0);
    send_pair(24'h5A5A5A, 24'hA5A5A5, {32'h5A5A5A00, 32'hA5A5A500}, 1'b0);
    n = 0;
    while (!(mon_active && mon_pos == 41) && n < 2 * FRAME_CYC) begin
      @(posedge clk_in); #1; n++;
    end
    check("reached_bit40", 64'(mon_pos), 64'(41));
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_reset_vals("midreset_outputs");
    if (exp_q.size() > 0) exp_q.pop_back();
    check("queue_after_reset", 64'(exp_q.size()), 64'(0));
    rst_in = 1'b0;
    measure_restart("midreset");
    send_pair(24'h00FF00, 24'hFF00FF, {32'h00FF0000, 32'hFF00FF00}, 1'b0);
    wait_frames(2);

    // Timing and completion summary checks
    check("sck_timing_errors", 64'(sck_errs), 64'(0));
    check("ws_timing_errors", 64'(ws_errs), 64'(0));
    check("ws_rises_seen", 64'(ws_rises >= 10), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
